// File: rtl/axis_burst_source.sv
// AXI4-Stream burst master: emits cfg_data beats of an incrementing ramp from cfg_start, TLAST on the final beat.
// Latency: first beat valid one cycle after run_flag is sampled high; one beat per cycle while tready is high.
// Backpressure: tready low holds tdata/tlast/tvalid stable; all outputs are registered, with no tready-to-output path.
module axis_burst_source #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH       = 64
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        run_flag,
  input  logic [CNTR_WIDTH-1:0]       cfg_data,
  input  logic [AXIS_TDATA_WIDTH-1:0] cfg_start,
  output logic                        trg_flag,
  output logic [CNTR_WIDTH-1:0]       sts_data,
  input  logic                        m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]                  state_q, state_d;
  logic [CNTR_WIDTH-1:0]       size_q, size_d;
  logic [CNTR_WIDTH-1:0]       cnt_q, cnt_d;
  logic [CNTR_WIDTH-1:0]       cnt_inc, cnt_inc2;
  logic [AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                        tvalid_q, tvalid_d;
  logic                        tlast_q, tlast_d;
  logic                        hs, start, final_beat;

  assign hs         = tvalid_q & m_axis_tready;
  assign start      = run_flag && (cfg_data != '0);
  assign cnt_inc    = cnt_q + CNTR_WIDTH'(1);
  assign cnt_inc2   = cnt_q + CNTR_WIDTH'(2);
  assign final_beat = (cnt_inc == size_q);

  always_ff @(posedge aclk) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (hs) begin
          if (final_beat)     state_d = DONE;
          else if (!run_flag) state_d = IDLE;
        end
      end
      DONE: if (!run_flag) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered datapath; everything holds unless a start or handshake occurs.
  always_comb begin
    size_d   = size_q;
    cnt_d    = cnt_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          size_d   = cfg_data;
          cnt_d    = '0;
          tdata_d  = cfg_start;
          tvalid_d = 1'b1;
          tlast_d  = (cfg_data == CNTR_WIDTH'(1));
        end
      end
      RUN: begin
        if (hs) begin
          cnt_d = cnt_inc;
          if (final_beat) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
          end else if (!run_flag) begin
            tvalid_d = 1'b0;
          end else begin
            tdata_d = tdata_q + AXIS_TDATA_WIDTH'(1);
            tlast_d = (cnt_inc2 == size_q);
          end
        end
      end
      default: tvalid_d = 1'b0;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      size_q   <= '0;
      cnt_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      size_q   <= size_d;
      cnt_q    <= cnt_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
    end
  end

  assign trg_flag      = (state_q == RUN);
  assign sts_data      = cnt_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_axis_burst_source.sv
// Bench for axis_burst_source: burst-level reference model compared every cycle, plus literal beat lists.
module tb_axis_burst_source;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        run_flag;
  logic [63:0] cfg_data;
  logic [31:0] cfg_start;
  logic        trg_flag;
  logic [63:0] sts_data;
  logic        m_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;

  axis_burst_source #(.AXIS_TDATA_WIDTH(32), .CNTR_WIDTH(64)) dut (
    .aclk(aclk), .aresetn(aresetn), .run_flag(run_flag), .cfg_data(cfg_data),
    .cfg_start(cfg_start), .trg_flag(trg_flag), .sts_data(sts_data),
    .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast)
  );

  always #5 aclk = ~aclk;

  int n_err = 0;
  int n_chk = 0;

  // Burst model: phase 0 = waiting, 1 = burst in flight, 2 = burst complete.
  int          ph = 0;
  logic [63:0] m_len = '0;
  logic [63:0] m_cnt = '0;
  logic [31:0] m_start = '0;

  always @(posedge aclk) begin
    if (!aresetn) begin
      ph    <= 0;
      m_cnt <= '0;
    end else begin
      case (ph)
        0: if (run_flag && cfg_data != 0) begin
             ph <= 1; m_len <= cfg_data; m_start <= cfg_start; m_cnt <= '0;
           end
        1: if (m_axis_tready) begin
             m_cnt <= m_cnt + 1;
             if (m_cnt + 1 == m_len) ph <= 2;
             else if (!run_flag)     ph <= 0;
           end
        default: if (!run_flag) ph <= 0;
      endcase
    end
  end

  logic [31:0] cap_d[$];
  bit          cap_l[$];
  int          trg_cyc = 0;
  int          vld_cyc = 0;
  int          last_cyc = 0;

  always @(posedge aclk) begin
    if (aresetn && m_axis_tvalid && m_axis_tready) begin
      cap_d.push_back(m_axis_tdata);
      cap_l.push_back(m_axis_tlast);
    end
    if (trg_flag) trg_cyc <= trg_cyc + 1;
    if (m_axis_tvalid) vld_cyc <= vld_cyc + 1;
    if (m_axis_tvalid && m_axis_tlast) last_cyc <= last_cyc + 1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp();
    logic        ev;
    logic [31:0] edata;
    ev    = (ph == 1);
    edata = m_start + m_cnt[31:0];
    chk("tvalid", m_axis_tvalid, ev);
    chk("trg_flag", trg_flag, ev);
    chk("sts_data", sts_data, m_cnt);
    if (ev) begin
      chk("tdata", m_axis_tdata, edata);
      chk("tlast", m_axis_tlast, (m_cnt + 1 == m_len));
    end
  endtask

  task automatic tick();
    @(negedge aclk);
    cmp();
    @(posedge aclk);
    #1;
  endtask

  task automatic run_until_done(input int max, input bit rnd);
    bit ok = 0;
    for (int n = 0; n < max; n++) begin
      if (rnd) m_axis_tready = 1'($urandom_range(0, 1));
      tick();
      if (ph == 2) begin ok = 1; break; end
    end
    chk("done_timeout", ok, 1);
  endtask

  int base, t0, v0, l0;
  logic [31:0] exp1 [4];
  logic [31:0] exp5 [4];
  bit pat [4];

  initial begin
    exp1 = '{32'h10, 32'h11, 32'h12, 32'h13};
    exp5 = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1};
    pat  = '{1'b1, 1'b0, 1'b0, 1'b1};
    aresetn = 0; run_flag = 0; cfg_data = 0; cfg_start = 0; m_axis_tready = 0;
    repeat (3) tick();
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_trg", trg_flag, 0);
    chk("rst_sts", sts_data, 0);
    aresetn = 1;
    tick();

    // Basic 4-beat burst, tready always high.
    base = cap_d.size(); t0 = trg_cyc;
    cfg_data = 4; cfg_start = 32'h10; m_axis_tready = 1; run_flag = 1;
    run_until_done(20, 0);
    tick(); tick();
    chk("t1_beats", cap_d.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_data", cap_d[base+i], exp1[i]);
      chk("t1_last", cap_l[base+i], (i == 3));
    end
    chk("t1_trg_cycles", trg_cyc - t0, 4);
    chk("t1_sts", sts_data, 4);
    chk("t1_done_vld", m_axis_tvalid, 0);
    run_flag = 0; tick();

    // Stalls with tready pattern 1,0,0,1.
    base = cap_d.size();
    cfg_data = 5; cfg_start = 0; run_flag = 1;
    for (int k = 0; k < 40; k++) begin
      m_axis_tready = pat[k%4];
      tick();
      if (ph == 2) break;
    end
    chk("t2_done", ph, 2);
    chk("t2_beats", cap_d.size() - base, 5);
    for (int i = 0; i < 5; i++) chk("t2_data", cap_d[base+i], i);
    chk("t2_last", cap_l[base+4], 1);
    run_flag = 0; m_axis_tready = 1; tick();

    // Single-beat burst, then zero-length request.
    base = cap_d.size();
    cfg_data = 1; cfg_start = 32'hABCD; run_flag = 1;
    run_until_done(10, 0);
    chk("t3_beats", cap_d.size() - base, 1);
    chk("t3_data", cap_d[base], 32'hABCD);
    chk("t3_last", cap_l[base], 1);
    run_flag = 0; tick();
    v0 = vld_cyc; t0 = trg_cyc;
    cfg_data = 0; run_flag = 1;
    repeat (5) tick();
    chk("t3_zero_vld", vld_cyc - v0, 0);
    chk("t3_zero_trg", trg_cyc - t0, 0);
    run_flag = 0; tick();

    // Abort at beat 3 of 10 while stalled.
    base = cap_d.size(); l0 = last_cyc;
    cfg_data = 10; cfg_start = 32'h100; m_axis_tready = 1; run_flag = 1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (cap_d.size() - base == 3) break;
    end
    m_axis_tready = 0; run_flag = 0;
    repeat (3) tick();
    chk("t4_held_vld", m_axis_tvalid, 1);
    chk("t4_held_data", m_axis_tdata, 32'h103);
    m_axis_tready = 1; tick();
    m_axis_tready = 0; tick();
    chk("t4_sts", sts_data, 4);
    chk("t4_vld", m_axis_tvalid, 0);
    chk("t4_trg", trg_flag, 0);
    chk("t4_no_last", last_cyc - l0, 0);
    chk("t4_beats", cap_d.size() - base, 4);

    // Data wrap, with cfg_data changed mid-burst.
    base = cap_d.size();
    cfg_data = 4; cfg_start = 32'hFFFFFFFE; run_flag = 1;
    tick();
    cfg_data = 2;
    run_until_done(60, 1);
    chk("t5_beats", cap_d.size() - base, 4);
    for (int i = 0; i < 4; i++) chk("t5_data", cap_d[base+i], exp5[i]);
    run_flag = 0; m_axis_tready = 1; tick();

    // Reset mid-burst, then a fresh burst.
    cfg_data = 8; cfg_start = 32'h55; run_flag = 1; m_axis_tready = 1;
    repeat (3) tick();
    chk("t6_pre_vld", m_axis_tvalid, 1);
    aresetn = 0; tick();
    chk("t6_rst_vld", m_axis_tvalid, 0);
    chk("t6_rst_data", m_axis_tdata, 0);
    chk("t6_rst_last", m_axis_tlast, 0);
    chk("t6_rst_trg", trg_flag, 0);
    chk("t6_rst_sts", sts_data, 0);
    aresetn = 1; tick();
    chk("t6_first_data", m_axis_tdata, 32'h55);
    chk("t6_first_sts", sts_data, 0);
    run_until_done(20, 0);
    chk("t6_sts", sts_data, 8);
    run_flag = 0; tick();

    // Randomised bursts with random backpressure, aborts and cfg noise.
    for (int it = 0; it < 25; it++) begin
      int n;
      cfg_data = 64'($urandom_range(1, 12));
      cfg_start = $urandom;
      run_flag = 1;
      n = 0;
      do begin
        m_axis_tready = 1'($urandom_range(0, 1));
        if (ph == 1) begin
          cfg_data = 64'($urandom_range(0, 12));
          if ($urandom_range(0, 19) == 0) run_flag = 0;
        end
        tick();
        n++;
      end while (!(ph == 2 || (ph == 0 && n > 1)) && n < 200);
      chk("rand_bound", (n < 200), 1);
      run_flag = 0;
      tick(); tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
